// File: rtl/win_scanner_pkg.sv
// Shared definitions for the Connect-4 win scanner: board geometry, piece
// codes, line kinds, FSM states and the line-start / addressing helpers.
package win_scanner_pkg;

    localparam int COLS    = 7;
    localparam int ROWS    = 6;
    localparam int WIN_LEN = 4;
    localparam int ADDR_W  = 6;

    // Diagonal starts: along the left/right edge (rows 0..DIAG_ROWS-1) and
    // along the bottom row (DIAG_COLS extra columns). Shorter diagonals are
    // never visited because they cannot hold WIN_LEN pieces.
    localparam int DIAG_ROWS = ROWS - WIN_LEN + 1;
    localparam int DIAG_COLS = COLS - WIN_LEN;

    localparam int ROW_BASE  = 0;
    localparam int COL_BASE  = ROW_BASE + ROWS;
    localparam int UR_BASE   = COL_BASE + COLS;
    localparam int UL_BASE   = UR_BASE + DIAG_ROWS + DIAG_COLS;
    localparam int NUM_LINES = UL_BASE + DIAG_ROWS + DIAG_COLS;

    typedef enum logic [1:0] {
        PIECE_EMPTY  = 2'b00,
        PIECE_RED    = 2'b01,
        PIECE_YELLOW = 2'b10
    } piece_e;

    typedef enum logic [1:0] {
        KIND_ROW     = 2'd0,
        KIND_COL     = 2'd1,
        KIND_DIAG_UR = 2'd2,
        KIND_DIAG_UL = 2'd3
    } line_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR0  = 3'd1,
        ST_CLR1  = 3'd2,
        ST_ADDR  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_FEED  = 3'd5,
        ST_CHECK = 3'd6,
        ST_DONE  = 3'd7
    } state_e;

    typedef struct packed {
        line_kind_e kind;
        logic [2:0] row;
        logic [2:0] col;
    } line_start_t;

    // First cell and direction of line number idx in scan order.
    function automatic line_start_t line_start(input logic [4:0] idx);
        line_start_t s;
        logic [4:0]  j;
        s = '{kind: KIND_ROW, row: 3'd0, col: 3'd0};
        j = '0;
        if (idx < 5'(COL_BASE)) begin
            s.kind = KIND_ROW;
            s.row  = 3'(idx);
        end else if (idx < 5'(UR_BASE)) begin
            s.kind = KIND_COL;
            s.col  = 3'(idx - 5'(COL_BASE));
        end else if (idx < 5'(UL_BASE)) begin
            s.kind = KIND_DIAG_UR;
            j = idx - 5'(UR_BASE);
            if (j < 5'(DIAG_ROWS)) s.row = 3'(5'(DIAG_ROWS - 1) - j);
            else                   s.col = 3'(j - 5'(DIAG_ROWS - 1));
        end else begin
            s.kind = KIND_DIAG_UL;
            j = idx - 5'(UL_BASE);
            s.col = 3'(COLS - 1);
            if (j < 5'(DIAG_ROWS)) s.row = 3'(5'(DIAG_ROWS - 1) - j);
            else                   s.col = 3'(5'(COLS - 1) - (j - 5'(DIAG_ROWS - 1)));
        end
        return s;
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [2:0] row, input logic [2:0] col);
        return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    // Address increment for one step along a line of the given kind.
    function automatic logic [ADDR_W-1:0] addr_step(input line_kind_e kind);
        logic [ADDR_W-1:0] step;
        case (kind)
            KIND_ROW:     step = ADDR_W'(1);
            KIND_COL:     step = ADDR_W'(COLS);
            KIND_DIAG_UR: step = ADDR_W'(COLS + 1);
            default:      step = ADDR_W'(COLS - 1);
        endcase
        return step;
    endfunction

endpackage

// File: rtl/win_scanner_cursor.sv
// Board cursor: tracks line kind, line index and current cell, and keeps the
// memory address of that cell in a register so mem_addr is glitch-free.
module scan_cursor
    import win_scanner_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              init_i,
    input  logic              advance_i,
    input  logic              next_line_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              end_of_line_o,
    output logic              last_line_o
);

    line_kind_e        kind_q, kind_d;
    logic [2:0]        row_q, row_d;
    logic [2:0]        col_q, col_d;
    logic [4:0]        line_q, line_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        next_idx;
    line_start_t       start_s;

    // Next cursor position: jump to a line start, or step along the line.
    always_comb begin
        kind_d   = kind_q;
        row_d    = row_q;
        col_d    = col_q;
        line_d   = line_q;
        addr_d   = addr_q;
        next_idx = init_i ? 5'd0 : line_q + 5'd1;
        start_s  = line_start(next_idx);
        if (init_i || next_line_i) begin
            kind_d = start_s.kind;
            row_d  = start_s.row;
            col_d  = start_s.col;
            line_d = next_idx;
            addr_d = cell_addr(start_s.row, start_s.col);
        end else if (advance_i) begin
            case (kind_q)
                KIND_ROW:     col_d = col_q + 3'd1;
                KIND_COL:     row_d = row_q + 3'd1;
                KIND_DIAG_UR: begin
                    row_d = row_q + 3'd1;
                    col_d = col_q + 3'd1;
                end
                default: begin
                    row_d = row_q + 3'd1;
                    col_d = col_q - 3'd1;
                end
            endcase
            addr_d = addr_q + addr_step(kind_q);
        end
    end

    // Cursor registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            kind_q <= KIND_ROW;
            row_q  <= 3'd0;
            col_q  <= 3'd0;
            line_q <= 5'd0;
            addr_q <= '0;
        end else begin
            kind_q <= kind_d;
            row_q  <= row_d;
            col_q  <= col_d;
            line_q <= line_d;
            addr_q <= addr_d;
        end
    end

    // The next step along the current line would leave the board.
    always_comb begin
        case (kind_q)
            KIND_ROW:     end_of_line_o = (col_q == 3'(COLS - 1));
            KIND_COL:     end_of_line_o = (row_q == 3'(ROWS - 1));
            KIND_DIAG_UR: end_of_line_o = (row_q == 3'(ROWS - 1)) || (col_q == 3'(COLS - 1));
            default:      end_of_line_o = (row_q == 3'(ROWS - 1)) || (col_q == 3'd0);
        endcase
    end

    assign last_line_o = (line_q == 5'(NUM_LINES - 1));
    assign mem_addr_o  = addr_q;

endmodule

// File: rtl/win_scanner.sv
// Connect-4 win scanner: walks every row, column and long diagonal, feeds
// each cell to the external sequence recognizer and reports the first winner.
//
// Handshake: start_i is a single-cycle request accepted only in IDLE (no
// back-pressure); busy_o is high from the cycle after acceptance through the
// DONE cycle; done_o pulses for exactly one cycle with winner_o already valid.
module win_scanner
    import win_scanner_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [1:0]        mem_data_i,
    output logic [1:0]        seq_piece_o,
    output logic              seq_next_o,
    output logic              seq_reset_o,
    input  logic [1:0]        seq_out_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        winner_o,
    output state_e            state_o
);

    state_e     state_q;
    logic [1:0] seq_piece_q;
    logic       seq_next_q;
    logic       seq_reset_q;
    logic       busy_q;
    logic       done_q;
    logic [1:0] winner_q;

    logic cur_init, cur_advance, cur_next_line;
    logic end_of_line, last_line;
    logic no_win;

    // Cursor commands, issued on the same edge the FSM leaves IDLE or CHECK.
    always_comb begin
        no_win        = (seq_out_i == PIECE_EMPTY);
        cur_init      = (state_q == ST_IDLE) && start_i;
        cur_advance   = (state_q == ST_CHECK) && no_win && !end_of_line;
        cur_next_line = (state_q == ST_CHECK) && no_win && end_of_line && !last_line;
    end

    scan_cursor u_cursor (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .init_i        (cur_init),
        .advance_i     (cur_advance),
        .next_line_i   (cur_next_line),
        .mem_addr_o    (mem_addr_o),
        .end_of_line_o (end_of_line),
        .last_line_o   (last_line)
    );

    // Scan FSM; each output is loaded on the edge entering the state it
    // belongs to, so seq_next/seq_reset come straight from flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            seq_piece_q <= PIECE_EMPTY;
            seq_next_q  <= 1'b0;
            seq_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            winner_q    <= PIECE_EMPTY;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q     <= ST_CLR0;
                        busy_q      <= 1'b1;
                        winner_q    <= PIECE_EMPTY;
                        seq_reset_q <= 1'b0;
                        seq_next_q  <= 1'b0;
                    end
                end
                ST_CLR0: begin
                    state_q    <= ST_CLR1;
                    seq_next_q <= 1'b1;
                end
                ST_CLR1: begin
                    state_q     <= ST_ADDR;
                    seq_next_q  <= 1'b0;
                    seq_reset_q <= 1'b1;
                end
                ST_ADDR: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Memory data is valid only now, one cycle after ADDR.
                    state_q     <= ST_FEED;
                    seq_piece_q <= mem_data_i;
                    seq_next_q  <= 1'b1;
                end
                ST_FEED: begin
                    state_q    <= ST_CHECK;
                    seq_next_q <= 1'b0;
                end
                ST_CHECK: begin
                    if (!no_win) begin
                        winner_q <= seq_out_i;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else if (end_of_line) begin
                        if (last_line) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            seq_reset_q <= 1'b0;
                            state_q     <= ST_CLR0;
                        end
                    end else begin
                        state_q <= ST_ADDR;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign seq_piece_o = seq_piece_q;
    assign seq_next_o  = seq_next_q;
    assign seq_reset_o = seq_reset_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign winner_o    = winner_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_win_scanner.sv
// Bench for win_scanner: board memory and four-in-a-row recognizer models,
// scoreboard of expected {mem_addr, seq_piece} per fed cell, timing checks.
module tb_win_scanner;
    import win_scanner_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [5:0] mem_addr;
    logic [1:0] mem_data;
    logic [1:0] seq_piece;
    logic       seq_next;
    logic       seq_reset;
    logic [1:0] seq_out = 2'b00;
    logic       busy;
    logic       done;
    logic [1:0] winner;
    state_e     state;

    logic [1:0] board [0:41];
    logic [7:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;

    win_scanner dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .mem_addr_o  (mem_addr),
        .mem_data_i  (mem_data),
        .seq_piece_o (seq_piece),
        .seq_next_o  (seq_next),
        .seq_reset_o (seq_reset),
        .seq_out_i   (seq_out),
        .busy_o      (busy),
        .done_o      (done),
        .winner_o    (winner),
        .state_o     (state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // synchronous-read board memory
    always @(posedge clk) mem_data <= board[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // recognizer model + feed monitor (samples on the falling edge)
    logic       prev_next = 1'b0;
    logic       prev_sreset = 1'b1;
    int         rc_cnt = 0;
    logic [1:0] rc_col = 2'b00;
    int         clear_cnt = 0;
    int         feed_cnt = 0;
    int         consec_err = 0;
    int         rst_chg_err = 0;
    logic [7:0] mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_next   = 1'b0;
            prev_sreset = 1'b1;
            rc_cnt      = 0;
            rc_col      = 2'b00;
            seq_out     = 2'b00;
        end else begin
            if (seq_next && prev_next) consec_err++;
            if ((seq_reset != prev_sreset) && seq_next) rst_chg_err++;
            if (seq_next && !prev_next) begin
                if (!seq_reset) begin
                    clear_cnt++;
                    rc_cnt  = 0;
                    rc_col  = 2'b00;
                    seq_out = 2'b00;
                end else begin
                    feed_cnt++;
                    check("sb_level", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        check("feed_addr_piece", 32'({mem_addr, seq_piece}), 32'(mon_e));
                    end
                    if (seq_piece != 2'b00 && seq_piece == rc_col) begin
                        rc_cnt++;
                    end else begin
                        rc_col = seq_piece;
                        rc_cnt = (seq_piece != 2'b00) ? 1 : 0;
                    end
                    seq_out = (rc_cnt >= 4) ? rc_col : 2'b00;
                end
            end
            prev_next   = seq_next;
            prev_sreset = seq_reset;
        end
    end

    // Reference walk of the 25 lines; pushes expected feeds, returns timing.
    task automatic build_expect(output int exp_done, output logic [1:0] exp_win,
                                output int exp_clears, output int exp_feeds);
        int r, c, dr, dc, a, run, cyc;
        logic [1:0] p, col;
        bit found;
        cyc = 0; exp_clears = 0; exp_feeds = 0; exp_win = 2'b00; found = 0;
        for (int l = 0; l < 25 && !found; l++) begin
            if (l < 6)       begin r = l;      c = 0;      dr = 1'b0; dc = 1;  end
            else if (l < 13) begin r = 0;      c = l - 6;  dr = 1;    dc = 0;  end
            else if (l < 16) begin r = 15 - l; c = 0;      dr = 1;    dc = 1;  end
            else if (l < 19) begin r = 0;      c = l - 15; dr = 1;    dc = 1;  end
            else if (l < 22) begin r = 21 - l; c = 6;      dr = 1;    dc = -1; end
            else             begin r = 0;      c = 27 - l; dr = 1;    dc = -1; end
            if (l < 6) dr = 0;
            cyc += 2; exp_clears++; run = 0; col = 2'b00;
            while (r >= 0 && r < 6 && c >= 0 && c < 7) begin
                a = r * 7 + c;
                p = board[a];
                cyc += 4; exp_feeds++;
                exp_q.push_back({6'(a), p});
                if (p != 2'b00 && p == col) run++;
                else begin col = p; run = (p != 2'b00) ? 1 : 0; end
                if (run >= 4) begin found = 1; exp_win = p; break; end
                r += dr; c += dc;
            end
        end
        exp_done = cyc + 1;
    endtask

    task automatic clear_board();
        for (int i = 0; i < 42; i++) board[i] = 2'b00;
    endtask

    // driver: one full scan with timing / count / handshake checks
    task automatic run_scan(input string name, input int busy_start_cyc, input int exp_last_addr);
        int exp_done, exp_clears, exp_feeds, c0, f0, cyc, done_cyc, first_next, last_chg;
        logic [1:0] exp_win;
        logic [5:0] prev_addr;
        build_expect(exp_done, exp_win, exp_clears, exp_feeds);
        c0 = clear_cnt; f0 = feed_cnt;
        @(negedge clk);
        start = 1'b1;
        cyc = 0; done_cyc = -1; first_next = -1; last_chg = -1; prev_addr = mem_addr;
        while (done_cyc < 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == busy_start_cyc);
            if (cyc == 1) check({name, "_busy_c1"}, 32'(busy), 32'd1);
            if (seq_next && first_next < 0) first_next = cyc;
            if (mem_addr != prev_addr) begin last_chg = cyc; prev_addr = mem_addr; end
            if (done) done_cyc = cyc;
        end
        check({name, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
        check({name, "_winner"}, 32'(winner), 32'(exp_win));
        check({name, "_busy_done"}, 32'(busy), 32'd1);
        check({name, "_first_next"}, 32'(first_next), 32'd2);
        check({name, "_clears"}, 32'(clear_cnt - c0), 32'(exp_clears));
        check({name, "_feeds"}, 32'(feed_cnt - f0), 32'(exp_feeds));
        check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        if (exp_last_addr >= 0) check({name, "_last_addr"}, 32'(last_chg), 32'(exp_last_addr));
        // start during DONE must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        check({name, "_idle"}, 32'(state), 32'(ST_IDLE));
        check({name, "_held"}, 32'(winner), 32'(exp_win));
        @(negedge clk);
        check({name, "_no_restart"}, 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_addr"}, 32'(mem_addr), 32'd0);
        check({name, "_piece"}, 32'(seq_piece), 32'd0);
        check({name, "_next"}, 32'(seq_next), 32'd0);
        check({name, "_sreset"}, 32'(seq_reset), 32'd1);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_winner"}, 32'(winner), 32'd0);
        check({name, "_state"}, 32'(state), 32'(ST_IDLE));
    endtask

    task automatic run_reset_mid();
        int d0, cl, fe, cyc;
        logic [1:0] w;
        build_expect(d0, w, cl, fe);
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_rst");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        clear_board();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // empty board, with a stray start while busy
        run_scan("empty", 50, -1);

        // red across row 0, columns 0..3
        clear_board();
        for (int i = 0; i < 4; i++) board[i] = 2'b01;
        run_scan("row_win", -1, 15);

        // column 6: red rows 0-1, yellow rows 2-5
        clear_board();
        board[6] = 2'b01; board[13] = 2'b01;
        board[20] = 2'b10; board[27] = 2'b10; board[34] = 2'b10; board[41] = 2'b10;
        run_scan("col_win", -1, -1);

        // red up-left diagonal (0,3),(1,2),(2,1),(3,0)
        clear_board();
        board[3] = 2'b01; board[9] = 2'b01; board[15] = 2'b01; board[21] = 2'b01;
        run_scan("diag_ul", -1, -1);

        // three at the end of row 0 plus one at start of row 1: no win
        clear_board();
        for (int i = 4; i < 8; i++) board[i] = 2'b01;
        run_scan("wrap", -1, -1);

        // sparse random boards
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 42; i++) begin
                int v;
                v = $urandom_range(0, 9);
                board[i] = (v < 6) ? 2'b00 : (v < 8) ? 2'b01 : 2'b10;
            end
            run_scan("random", -1, -1);
        end

        // asynchronous reset mid-scan, then a clean full rescan
        clear_board();
        run_reset_mid();
        run_scan("after_rst", -1, -1);

        check("next_consecutive", 32'(consec_err), 32'd0);
        check("sreset_while_next", 32'(rst_chg_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
